// File: rtl/gate_sweep_checker_if.sv
// Bus between the truth-table sweeper and its user: stimulus out, DUT response in,
// sweep control and result reporting.
interface gate_sweep_checker_if #(
   parameter int N_IN = 2
);
   logic            start;
   logic [2:0]      op;
   logic            dut_y;
   logic [N_IN-1:0] stim;
   logic            exp_y;
   logic            busy;
   logic            done;
   logic            pass;
   logic [N_IN:0]   err_count;
   logic [N_IN-1:0] first_fail;
   logic            fail_seen;

   modport slave (
      input  start, op, dut_y,
      output stim, exp_y, busy, done, pass, err_count, first_fail, fail_seen
   );

   modport master (
      output start, op, dut_y,
      input  stim, exp_y, busy, done, pass, err_count, first_fail, fail_seen
   );
endinterface

// File: rtl/gate_sweep_checker.sv
// Sweeps every input vector of an N_IN-input gate, waits SETTLE cycles per vector,
// then compares the DUT output against a golden model selected by op.
module gate_sweep_checker #(
   parameter int N_IN   = 2,
   parameter int SETTLE = 2
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   gate_sweep_checker_if.slave  bus
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SETTLE = 2'd1,
      S_CHECK  = 2'd2,
      S_DONE   = 2'd3
   } state_t;

   localparam logic [N_IN-1:0] ALL_ONES    = {N_IN{1'b1}};
   localparam logic [3:0]      SETTLE_LAST = 4'(SETTLE - 1);
   localparam logic [N_IN:0]   ERR_ONE     = (N_IN+1)'(1);

   state_t          state_q;
   logic [2:0]      op_q;
   logic [N_IN-1:0] stim_q;
   logic [3:0]      cnt_q;
   logic [N_IN:0]   err_count_q;
   logic [N_IN-1:0] first_fail_q;
   logic            fail_seen_q;
   logic            busy_q;
   logic            done_q;
   logic            pass_q;
   logic            exp_y_d;
   logic            mismatch_d;

   // BUF and NOT look only at bit 0; the rest reduce over the whole vector.
   function automatic logic golden(input logic [2:0] op, input logic [N_IN-1:0] v);
      logic y;
      case (op)
         3'b000:  y = &v;
         3'b001:  y = |v;
         3'b010:  y = ~(&v);
         3'b011:  y = ~(|v);
         3'b100:  y = ^v;
         3'b101:  y = ~(^v);
         3'b110:  y = v[0];
         3'b111:  y = ~v[0];
         default: y = 1'b0;
      endcase
      return y;
   endfunction

   assign exp_y_d    = golden(op_q, stim_q);
   assign mismatch_d = (bus.dut_y != exp_y_d);

   // Sweep controller; all outputs are held in registers here.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= S_IDLE;
         op_q         <= 3'b000;
         stim_q       <= '0;
         cnt_q        <= 4'd0;
         err_count_q  <= '0;
         first_fail_q <= '0;
         fail_seen_q  <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         pass_q       <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (bus.start) begin
                  op_q         <= bus.op;
                  stim_q       <= '0;
                  cnt_q        <= 4'd0;
                  err_count_q  <= '0;
                  first_fail_q <= '0;
                  fail_seen_q  <= 1'b0;
                  pass_q       <= 1'b0;
                  busy_q       <= 1'b1;
                  state_q      <= S_SETTLE;
               end
            end
            S_SETTLE: begin
               cnt_q <= cnt_q + 4'd1;
               if (cnt_q == SETTLE_LAST) begin
                  state_q <= S_CHECK;
               end
            end
            S_CHECK: begin
               if (mismatch_d) begin
                  err_count_q <= err_count_q + ERR_ONE;
                  if (!fail_seen_q) begin
                     first_fail_q <= stim_q;
                     fail_seen_q  <= 1'b1;
                  end
               end
               cnt_q <= 4'd0;
               // The sweep stops at all-ones rather than wrapping back to zero.
               if (stim_q == ALL_ONES) begin
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= S_DONE;
               end else begin
                  stim_q  <= stim_q + {{(N_IN-1){1'b0}}, 1'b1};
                  state_q <= S_SETTLE;
               end
            end
            S_DONE: begin
               done_q  <= 1'b0;
               pass_q  <= (err_count_q == '0);
               state_q <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.stim       = stim_q;
   assign bus.exp_y      = exp_y_d;
   assign bus.busy       = busy_q;
   assign bus.done       = done_q;
   assign bus.pass       = pass_q;
   assign bus.err_count  = err_count_q;
   assign bus.first_fail = first_fail_q;
   assign bus.fail_seen  = fail_seen_q;

endmodule

// File: tb/tb_gate_sweep_checker.sv
// Directed bench for gate_sweep_checker: two instances (N_IN=2/SETTLE=2 and N_IN=3/SETTLE=1)
// driven by behavioural gate models, with sweep results checked through a scoreboard queue.
module tb_gate_sweep_checker;

   typedef struct {
      int errs;
      int ff;
      int fs;
      int pass;
      int lat;
      int stim_end;
   } exp_t;

   logic clk;
   logic rst;
   int   compared = 0;
   int   mismatched = 0;
   int   mode_a = 0;
   int   mode_b = 0;
   exp_t sb[$];

   gate_sweep_checker_if #(.N_IN(2)) if_a ();
   gate_sweep_checker_if #(.N_IN(3)) if_b ();

   gate_sweep_checker #(.N_IN(2), .SETTLE(2)) dut_a (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (if_a.slave)
   );

   gate_sweep_checker #(.N_IN(3), .SETTLE(1)) dut_b (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (if_b.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Gate under test: 0 = OR, 1 = stuck at 0, 2 = AND, 3 = parity
   function automatic logic dut_model(input int mode, input int v, input int n);
      int ones;
      ones = 0;
      for (int i = 0; i < n; i++) ones += (v >> i) & 1;
      case (mode)
         0:       return (ones != 0);
         1:       return 1'b0;
         2:       return (ones == n);
         3:       return ones[0];
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic gold(input logic [2:0] op, input int v, input int n);
      int   ones;
      logic all1, any1, par;
      ones = 0;
      for (int i = 0; i < n; i++) ones += (v >> i) & 1;
      all1 = (ones == n);
      any1 = (ones != 0);
      par  = ones[0];
      case (op)
         3'b000:  return all1;
         3'b001:  return any1;
         3'b010:  return !all1;
         3'b011:  return !any1;
         3'b100:  return par;
         3'b101:  return !par;
         3'b110:  return v[0];
         default: return !v[0];
      endcase
   endfunction

   assign if_a.dut_y = dut_model(mode_a, int'(if_a.stim), 2);
   assign if_b.dut_y = dut_model(mode_b, int'(if_b.stim), 3);

   task automatic check(input string tag, input int obs, input int exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic set_start(input int sel, input logic v);
      if (sel == 0) if_a.start = v;
      else          if_b.start = v;
   endtask

   task automatic set_op(input int sel, input logic [2:0] v);
      if (sel == 0) if_a.op = v;
      else          if_b.op = v;
   endtask

   task automatic snap(input int sel, output int stim, output int busy, output int done,
                       output int pass, output int errc, output int ff, output int fs,
                       output int expy);
      if (sel == 0) begin
         stim = int'(if_a.stim); busy = int'(if_a.busy); done = int'(if_a.done);
         pass = int'(if_a.pass); errc = int'(if_a.err_count);
         ff = int'(if_a.first_fail); fs = int'(if_a.fail_seen); expy = int'(if_a.exp_y);
      end else begin
         stim = int'(if_b.stim); busy = int'(if_b.busy); done = int'(if_b.done);
         pass = int'(if_b.pass); errc = int'(if_b.err_count);
         ff = int'(if_b.first_fail); fs = int'(if_b.fail_seen); expy = int'(if_b.exp_y);
      end
   endtask

   task automatic check_reset(input int sel, input string tag);
      int stim, busy, done, pass, errc, ff, fs, expy;
      snap(sel, stim, busy, done, pass, errc, ff, fs, expy);
      check({tag, "_stim"}, stim, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_done"}, done, 0);
      check({tag, "_pass"}, pass, 0);
      check({tag, "_errc"}, errc, 0);
      check({tag, "_ff"},   ff,   0);
      check({tag, "_fs"},   fs,   0);
      check({tag, "_expy"}, expy, 0);
   endtask

   // Push the modelled outcome, run one sweep, then pop and compare on done.
   task automatic run(input int sel, input logic [2:0] op, input int mode, input bit disturb);
      int   n_in, settle, errs, ff, n, got;
      int   stim, busy, done, pass, errc, ffo, fs, expy;
      exp_t e;
      n_in   = (sel == 0) ? 2 : 3;
      settle = (sel == 0) ? 2 : 1;
      errs = 0; ff = 0;
      for (int v = 0; v < (1 << n_in); v++) begin
         if (dut_model(mode, v, n_in) != gold(op, v, n_in)) begin
            if (errs == 0) ff = v;
            errs++;
         end
      end
      e.errs = errs; e.ff = ff; e.fs = (errs > 0); e.pass = (errs == 0);
      e.lat = (1 << n_in) * (settle + 1); e.stim_end = (1 << n_in) - 1;
      sb.push_back(e);

      if (sel == 0) mode_a = mode; else mode_b = mode;
      set_op(sel, op);
      set_start(sel, 1'b1);
      @(posedge clk);
      n = 0; got = 0;
      while (n < 200 && got == 0) begin
         @(negedge clk);
         if (n == 0) set_start(sel, 1'b0);
         if (n == 1) begin
            snap(sel, stim, busy, done, pass, errc, ffo, fs, expy);
            check("busy_mid", busy, 1);
         end
         if (disturb && n == 4) begin
            set_op(sel, ~op);
            set_start(sel, 1'b1);
         end
         if (disturb && n == 5) set_start(sel, 1'b0);
         snap(sel, stim, busy, done, pass, errc, ffo, fs, expy);
         if (done == 1) got = 1;
         else begin
            @(posedge clk);
            n++;
         end
      end
      set_op(sel, op);
      e = sb.pop_front();
      check("done_seen", got, 1);
      check("done_latency", n, e.lat);
      check("stim_end", stim, e.stim_end);
      check("busy_in_done", busy, 0);
      @(posedge clk);
      @(negedge clk);
      snap(sel, stim, busy, done, pass, errc, ffo, fs, expy);
      check("done_pulse_end", done, 0);
      check("err_count", errc, e.errs);
      check("first_fail", ffo, e.ff);
      check("fail_seen", fs, e.fs);
      check("pass", pass, e.pass);
      check("stim_held", stim, e.stim_end);
   endtask

   initial begin
      int n, stim, busy, done, pass, errc, ff, fs, expy;
      rst = 1'b1;
      if_a.start = 1'b0; if_a.op = 3'b000;
      if_b.start = 1'b0; if_b.op = 3'b000;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      check_reset(0, "rst_a");
      check_reset(1, "rst_b");

      run(0, 3'b001, 0, 1'b0);   // OR, correct DUT
      run(0, 3'b000, 1, 1'b0);   // AND, stuck 0
      run(0, 3'b001, 1, 1'b0);   // OR, stuck 0
      run(0, 3'b010, 2, 1'b0);   // NAND vs AND DUT
      run(0, 3'b111, 1, 1'b0);   // NOT, stuck 0
      run(1, 3'b100, 3, 1'b1);   // XOR, parity DUT, op toggle + start while busy
      run(1, 3'b110, 3, 1'b0);   // BUF vs parity DUT

      // Reset in the SETTLE phase of vector 2'b10
      mode_a = 0;
      if_a.op = 3'b001;
      if_a.start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      if_a.start = 1'b0;
      n = 0;
      while (n < 100 && if_a.stim !== 2'b10) begin
         @(negedge clk);
         n++;
      end
      check("reach_vec2", int'(if_a.stim), 2);
      snap(0, stim, busy, done, pass, errc, ff, fs, expy);
      check("vec2_busy", busy, 1);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check_reset(0, "midrst");
      rst = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check_reset(0, "idle_after_rst");
      run(0, 3'b001, 0, 1'b0);   // clean sweep after reset

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
